// File: rtl/tilt_pkg.sv
// tilt_pkg -- shared definitions for the tilt direction decoder.
//   * direction indices (bit positions in dir_level / dir_pulse)
//   * per-channel state encoding
//   * {sign, mag} field-slice helpers, usable for any MAG_W up to 31
package tilt_pkg;

  localparam int NUM_DIRS  = 4;
  localparam int DIR_RIGHT = 0;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ACTIVE = 2'd2
  } ch_state_e;

  // Sign bit sits directly above the magnitude bits.
  function automatic logic fld_sign(input logic [31:0] fld, input int mag_w);
    return fld[mag_w];
  endfunction

  function automatic logic [31:0] fld_mag(input logic [31:0] fld, input int mag_w);
    return fld & ((32'd1 << mag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/tilt_direction_decoder_channel.sv
// tilt_channel -- one direction's debounce FSM.
//   IDLE -> ARMING on qualifying samples, activation requested when
//   HOLD_SAMPLES consecutive qualifying samples have been seen; the top
//   grants at most one request. ACTIVE releases after RELEASE_SAMPLES
//   consecutive non-qualifying samples.
//   With TILT_AUTO_REPEAT_EN defined, an ACTIVE channel also emits repeat
//   pulses REPEAT_DELAY cycles after activation, then every REPEAT_PERIOD.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   sample_valid_i    new-sample strobe; the FSM only advances on it
//   qual_on_i         sample qualifies at the arming threshold
//   qual_off_i        sample qualifies at the hysteresis (hold) threshold
//   block_i           some other channel is ACTIVE
//   grant_i           arbitration result for this cycle's request
//   req_o             activation request (combinational)
//   active_o          channel is ACTIVE (direction level)
//   pulse_o           one-cycle press / repeat pulse
module tilt_channel
  import tilt_pkg::*;
#(
  parameter int HOLD_SAMPLES    = 3,
  parameter int RELEASE_SAMPLES = 2
`ifdef TILT_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sample_valid_i,
  input  logic qual_on_i,
  input  logic qual_off_i,
  input  logic block_i,
  input  logic grant_i,
  output logic req_o,
  output logic active_o,
  output logic pulse_o
);

  localparam int HC_W = $clog2(HOLD_SAMPLES) + 1;
  localparam int RC_W = $clog2(RELEASE_SAMPLES) + 1;

  ch_state_e         state_q, state_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic [RC_W-1:0]   rel_q, rel_d;
  logic              pulse_q, pulse_d;
  logic              act_pulse;
  logic              hold_done, rel_done;

  // True when the sample under evaluation would complete the count.
  assign hold_done = (hold_q >= HC_W'(HOLD_SAMPLES - 1));
  assign rel_done  = (rel_q  >= RC_W'(RELEASE_SAMPLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      rel_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rel_d     = rel_q;
    req_o     = 1'b0;
    act_pulse = 1'b0;
    unique case (state_q)
      // IDLE holds hold_q at 0, so both states share the counting path;
      // with HOLD_SAMPLES==1 the first qualifying sample requests directly.
      ST_IDLE, ST_ARMING: begin
        if (sample_valid_i) begin
          if (block_i || !qual_on_i) begin
            state_d = ST_IDLE;
            hold_d  = '0;
          end else if (hold_done) begin
            req_o  = 1'b1;
            hold_d = '0;
            if (grant_i) begin
              state_d   = ST_ACTIVE;
              rel_d     = '0;
              act_pulse = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_ARMING;
            if (hold_q != '1) hold_d = hold_q + 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (sample_valid_i) begin
          if (qual_off_i) begin
            rel_d = '0;
          end else if (rel_done) begin
            state_d = ST_IDLE;
            rel_d   = '0;
          end else if (rel_q != '1) begin
            rel_d = rel_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
        rel_d   = '0;
      end
    endcase
  end

`ifdef TILT_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RT_W    = $clog2(RPT_MAX) + 1;

  logic [RT_W-1:0] rpt_q, rpt_d;
  logic            first_q, first_d;
  logic            rpt_fire;
  logic [RT_W-1:0] rpt_target;

  assign rpt_target = first_q ? RT_W'(REPEAT_DELAY) : RT_W'(REPEAT_PERIOD);

  // Timer runs every clk while the channel stays ACTIVE; it is rearmed
  // (cleared, first interval = delay) whenever the channel is not ACTIVE.
  always_comb begin
    rpt_d    = '0;
    first_d  = 1'b1;
    rpt_fire = 1'b0;
    if (state_q == ST_ACTIVE && state_d == ST_ACTIVE) begin
      first_d = first_q;
      if ((rpt_q + RT_W'(1)) == rpt_target) begin
        rpt_fire = 1'b1;
        first_d  = 1'b0;
      end else begin
        rpt_d = rpt_q + RT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end

  assign pulse_d = act_pulse | rpt_fire;
`else
  assign pulse_d = act_pulse;
`endif

  assign active_o = (state_q == ST_ACTIVE);
  assign pulse_o  = pulse_q;

endmodule

// File: rtl/tilt_direction_decoder.sv
// tilt_direction_decoder -- turns accelerometer samples into debounced,
// mutually exclusive direction levels and one-cycle press pulses.
//   Decodes the X/Y {sign, mag} fields, qualifies each direction against
//   the arming / hysteresis thresholds, and arbitrates activation requests
//   so only one direction is ever held.
//   Optional: define TILT_AUTO_REPEAT_EN for auto-repeat pulses while held.
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   sample_valid  one-cycle strobe, acl_data carries a new sample
//   acl_data      {Y, X, Z}, each field {sign, mag[MAG_W-1:0]}; Z unused
//   dir_level     held direction: [0] right [1] left [2] up [3] down
//   dir_pulse     one-cycle press pulse, same bit order
module tilt_direction_decoder
  import tilt_pkg::*;
#(
  parameter int MAG_W           = 4,
  parameter int ON_MIN          = 8,
  parameter int OFF_MIN         = 6,
  parameter int MAX_MAG         = 11,
  parameter int HOLD_SAMPLES    = 3,
  parameter int RELEASE_SAMPLES = 2,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [3*(MAG_W+1)-1:0] acl_data,
  output logic [3:0]             dir_level,
  output logic [3:0]             dir_pulse
);

  localparam int FW = MAG_W + 1;

  if (OFF_MIN > ON_MIN || HOLD_SAMPLES < 1 || RELEASE_SAMPLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("tilt_direction_decoder: illegal parameter combination");
  end

  logic [FW-1:0]    x_fld, y_fld;
  logic             x_sgn, y_sgn;
  logic [MAG_W-1:0] x_mag, y_mag;
  logic             x_on, x_off, y_on, y_off;
  logic             unused_z;

  assign y_fld    = acl_data[3*FW-1 -: FW];
  assign x_fld    = acl_data[2*FW-1 -: FW];
  assign unused_z = ^acl_data[FW-1:0];

  assign x_sgn = fld_sign(32'(x_fld), MAG_W);
  assign y_sgn = fld_sign(32'(y_fld), MAG_W);
  assign x_mag = MAG_W'(fld_mag(32'(x_fld), MAG_W));
  assign y_mag = MAG_W'(fld_mag(32'(y_fld), MAG_W));

  // Over-range magnitudes are rejected at both thresholds.
  assign x_on  = (int'(x_mag) >= ON_MIN)  && (int'(x_mag) <= MAX_MAG);
  assign x_off = (int'(x_mag) >= OFF_MIN) && (int'(x_mag) <= MAX_MAG);
  assign y_on  = (int'(y_mag) >= ON_MIN)  && (int'(y_mag) <= MAX_MAG);
  assign y_off = (int'(y_mag) >= OFF_MIN) && (int'(y_mag) <= MAX_MAG);

  logic [NUM_DIRS-1:0] qual_on, qual_off, block, req, grant, active, pulse;

  assign qual_on[DIR_RIGHT]  =  x_sgn & x_on;
  assign qual_on[DIR_LEFT]   = ~x_sgn & x_on;
  assign qual_on[DIR_UP]     =  y_sgn & y_on;
  assign qual_on[DIR_DOWN]   = ~y_sgn & y_on;
  assign qual_off[DIR_RIGHT] =  x_sgn & x_off;
  assign qual_off[DIR_LEFT]  = ~x_sgn & x_off;
  assign qual_off[DIR_UP]    =  y_sgn & y_off;
  assign qual_off[DIR_DOWN]  = ~y_sgn & y_off;

  // Opposite directions on one axis never request together (sign differs),
  // so arbitration reduces to X-axis vs Y-axis; ties go to X.
  logic x_req, y_req, y_wins;

  assign x_req  = req[DIR_RIGHT] | req[DIR_LEFT];
  assign y_req  = req[DIR_UP]    | req[DIR_DOWN];
  assign y_wins = y_req && (!x_req || (y_mag > x_mag));

  always_comb begin
    grant = '0;
    if (y_wins) begin
      grant[DIR_UP]   = req[DIR_UP];
      grant[DIR_DOWN] = req[DIR_DOWN];
    end else begin
      grant[DIR_RIGHT] = req[DIR_RIGHT];
      grant[DIR_LEFT]  = req[DIR_LEFT];
    end
  end

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_ch
    // Any other channel holding the level locks this one out of arming.
    assign block[d] = |(active & ~(NUM_DIRS'(1) << d));

    tilt_channel #(
      .HOLD_SAMPLES    (HOLD_SAMPLES),
      .RELEASE_SAMPLES (RELEASE_SAMPLES)
`ifdef TILT_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk_i          (clk),
      .rst_i          (reset),
      .sample_valid_i (sample_valid),
      .qual_on_i      (qual_on[d]),
      .qual_off_i     (qual_off[d]),
      .block_i        (block[d]),
      .grant_i        (grant[d]),
      .req_o          (req[d]),
      .active_o       (active[d]),
      .pulse_o        (pulse[d])
    );
  end

  assign dir_level = active;
  assign dir_pulse = pulse;

endmodule

// File: tb/tb_tilt_direction_decoder.sv
module tb_tilt_direction_decoder;

`ifdef TILT_AUTO_REPEAT_EN
  localparam int  RD  = 4;
  localparam int  RP  = 3;
  localparam bit  RPT = 1'b1;
`else
  localparam int  RD  = 50_000_000;
  localparam int  RP  = 10_000_000;
  localparam bit  RPT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [14:0] acl_data;
  logic [3:0]  dir_level;
  logic [3:0]  dir_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tilt_direction_decoder #(
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .acl_data     (acl_data),
    .dir_level    (dir_level),
    .dir_pulse    (dir_pulse)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One sample strobe; returns at the negedge after the capturing edge,
  // i.e. where the sample's effect on the outputs is first visible.
  task automatic strobe(input logic [4:0] y, input logic [4:0] x);
    @(negedge clk);
    acl_data     = {y, x, 5'b11111};
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    acl_data     = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", dir_level, 4'b0000);
    chk("rst_pulse", dir_pulse, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_pulse", dir_pulse, 4'b0000);

    // Qualifying data without strobes must not advance anything.
    acl_data = {5'b00000, 5'b11001, 5'b00000};
    repeat (5) @(negedge clk);
    chk("no_strobe_level", dir_level, 4'b0000);

    // Right activation after three mag-9 samples.
    strobe(5'b00000, 5'b11001);
    chk("arm1_level", dir_level, 4'b0000);
    strobe(5'b00000, 5'b11001);
    chk("arm2_level", dir_level, 4'b0000);
    strobe(5'b00000, 5'b11001);
    chk("act_level", dir_level, 4'b0001);
    chk("act_pulse", dir_pulse, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("hold_pulse_%0d", k), dir_pulse,
          (RPT && (k == 4 || k == 7)) ? 4'b0001 : 4'b0000);
    end
    chk("held_level", dir_level, 4'b0001);

    // Hysteresis: mag 7 keeps it, two mag-5 samples release it.
    strobe(5'b00000, 5'b10111);
    chk("hyst7a_level", dir_level, 4'b0001);
    strobe(5'b00000, 5'b10111);
    chk("hyst7b_level", dir_level, 4'b0001);
    strobe(5'b00000, 5'b10101);
    chk("rel1_level", dir_level, 4'b0001);
    strobe(5'b00000, 5'b10101);
    chk("rel2_level", dir_level, 4'b0000);
    chk("rel_pulse", dir_pulse, 4'b0000);

    // Glitch: 9, 9, 4, 9 never reaches three in a row.
    strobe(5'b00000, 5'b11001);
    strobe(5'b00000, 5'b11001);
    strobe(5'b00000, 5'b10100);
    strobe(5'b00000, 5'b11001);
    chk("glitch_level", dir_level, 4'b0000);
    strobe(5'b00000, 5'b10000);
    // Over-range magnitude 12 is not qualifying.
    for (int i = 0; i < 3; i++) strobe(5'b00000, 5'b11100);
    chk("overrange_level", dir_level, 4'b0000);
    chk("overrange_pulse", dir_pulse, 4'b0000);

    // Simultaneous: Y mag 10 beats X mag 9 -> up.
    for (int i = 0; i < 3; i++) strobe(5'b11010, 5'b11001);
    chk("simul_up_level", dir_level, 4'b0100);
    chk("simul_up_pulse", dir_pulse, 4'b0100);
    strobe(5'b00000, 5'b00000);
    strobe(5'b00000, 5'b00000);
    chk("simul_up_rel", dir_level, 4'b0000);
    // Tie at mag 9 -> X axis (right) wins.
    for (int i = 0; i < 3; i++) strobe(5'b11001, 5'b11001);
    chk("tie_right_level", dir_level, 4'b0001);
    chk("tie_right_pulse", dir_pulse, 4'b0001);
    strobe(5'b00000, 5'b00000);
    strobe(5'b00000, 5'b00000);
    chk("tie_rel", dir_level, 4'b0000);

    // Lockout: left held, down qualifies but may not arm.
    for (int i = 0; i < 3; i++) strobe(5'b00000, 5'b01001);
    chk("left_level", dir_level, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      strobe(5'b01001, 5'b01001);
      chk($sformatf("lockout_%0d", i), dir_level, 4'b0010);
    end
    strobe(5'b01001, 5'b00000);
    strobe(5'b01001, 5'b00000);
    chk("left_rel_level", dir_level, 4'b0000);
    strobe(5'b01001, 5'b00000);
    strobe(5'b01001, 5'b00000);
    chk("down_arm_level", dir_level, 4'b0000);
    strobe(5'b01001, 5'b00000);
    chk("down_level", dir_level, 4'b1000);
    chk("down_pulse", dir_pulse, 4'b1000);
    strobe(5'b00000, 5'b00000);
    strobe(5'b00000, 5'b00000);
    chk("down_rel", dir_level, 4'b0000);

    // Reset in the middle of arming discards the count.
    strobe(5'b00000, 5'b11001);
    strobe(5'b00000, 5'b11001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midarm_rst_level", dir_level, 4'b0000);
    strobe(5'b00000, 5'b11001);
    chk("midarm_after_level", dir_level, 4'b0000);
    chk("midarm_after_pulse", dir_pulse, 4'b0000);

    // Reset while active clears the level asynchronously, no pulse after.
    strobe(5'b00000, 5'b00000);
    for (int i = 0; i < 3; i++) strobe(5'b00000, 5'b11001);
    chk("pre_rst_level", dir_level, 4'b0001);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_level", dir_level, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rel_pulse", dir_pulse, 4'b0000);
    chk("rst_rel_level", dir_level, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tilt_direction_decoder.md
Name: tilt_direction_decoder

Overview:
- Sequential successor to the combinational tilt-to-button mapping.
- Converts sampled accelerometer axis fields into debounced, mutually exclusive direction levels and one-cycle press pulses for the game/menu logic.
- Generalised magnitude width, hysteresis thresholds, persistence counts and optional auto-repeat.
- Sits between the accelerometer SPI reader and the game/menu FSM.

Parameters:
- MAG_W, 4, magnitude bits per axis field (field = 1 sign bit + MAG_W magnitude bits).
- ON_MIN, 8, minimum magnitude to qualify a direction.
- OFF_MIN, 6, a held direction stays qualified while magnitude >= OFF_MIN (hysteresis); requires OFF_MIN <= ON_MIN.
- MAX_MAG, 11, magnitudes above this are non-qualifying (glitch/overrange reject).
- HOLD_SAMPLES, 3, consecutive qualifying samples needed to activate (>=1).
- RELEASE_SAMPLES, 2, consecutive non-qualifying samples needed to release (>=1).
- REPEAT_DELAY, 50_000_000, clk cycles from activation to first repeat pulse (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 10_000_000, clk cycles between subsequent repeat pulses (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_valid  in  1  one-cycle strobe: acl_data holds a new sample
- acl_data  in  3*(MAG_W+1)  packed as {Y, X, Z}, each field = {sign, mag}; Z is ignored
- dir_level  out  4  held direction: bit0 right, bit1 left, bit2 up, bit3 down
- dir_pulse  out  4  one-cycle press pulse, same bit order

Behaviour:
- Reset: asynchronous and active-high. Clears dir_level, dir_pulse, all counters and repeat timers, and forces every channel to IDLE. Applies mid-operation too; no pulse is generated on release of reset.
- Field decode:
  - right = X.sign==1; left = X.sign==0; up = Y.sign==1; down = Y.sign==0.
  - Magnitude is compared unsigned, MAG_W bits.
- Qualify, per direction:
  - From IDLE or ARMING: sign matches and ON_MIN <= mag <= MAX_MAG.
  - From ACTIVE: sign matches and OFF_MIN <= mag <= MAX_MAG.
- Channel FSM, one per direction. Advances only on sample_valid; holds otherwise.
  - IDLE -> ARMING on a qualifying sample; hold_cnt = 1. If HOLD_SAMPLES==1, go directly to the activation check.
  - ARMING:
    - Each qualifying sample increments hold_cnt.
    - Reaching HOLD_SAMPLES requests activation.
    - A non-qualifying sample returns the channel to IDLE with hold_cnt = 0.
  - ACTIVE:
    - dir_level bit is 1.
    - A non-qualifying sample increments rel_cnt; a qualifying sample clears it.
    - rel_cnt reaching RELEASE_SAMPLES -> IDLE, level drops the next cycle.
- Arbitration (single winner):
  - At most one dir_level bit may be set.
  - A channel may not arm while another channel is ACTIVE; it stays IDLE.
  - Two requests on the same sample: larger magnitude wins; on a tie the X axis (right/left) wins. The loser returns to IDLE.
- Latency: sample_valid at cycle t carrying the activating sample -> dir_level bit and dir_pulse bit both high at t+1. dir_pulse lasts exactly one cycle.
- Release latency: the sample completing RELEASE_SAMPLES at cycle t -> level low at t+1. No pulse on release.
- Counter widths are $clog2 of the respective maximum plus 1. Counters saturate and never wrap.

Optional Feature:
- Macro: TILT_AUTO_REPEAT_EN.
- Defined:
  - While a channel is ACTIVE, a clk-cycle timer runs regardless of sample_valid.
  - REPEAT_DELAY cycles after activation -> one-cycle dir_pulse, then one every REPEAT_PERIOD cycles.
  - The timer clears on release or reset.
- Undefined: exactly one pulse per activation; no timer logic is synthesised.

Decomposition:
- Package tilt_pkg holds:
  - direction index constants DIR_RIGHT=0, DIR_LEFT=1, DIR_UP=2, DIR_DOWN=3;
  - channel state encoding (IDLE, ARMING, ACTIVE);
  - the field-slice helpers for {sign, mag}.
- Sub-module tilt_channel: one direction's FSM, counters and repeat timer, instantiated 4x. The top level holds decode and arbitration.

Test Plan (default parameters; X field = acl_data[9:5], Y field = acl_data[14:10]):
- Reset then three strobes with X=5'b1_1001 (mag 9) -> after the 3rd strobe, dir_level=4'b0001 and dir_pulse=4'b0001 for exactly one cycle.
- Hysteresis: after right is active, strobes with X mag 7 -> level stays 1; two strobes with mag 5 -> level 0 one cycle after the 2nd.
- Glitch reject: strobe sequence mag 9, 9, 4, 9 -> no activation; mag 12 (>MAX_MAG) for three strobes -> no activation.
- Simultaneous: X=1_1001 and Y=1_1010 for three strobes -> up wins (dir_level=4'b0100). Equal mags of 9 -> right wins.
- Lockout: with left active, Y=0_1001 (down) for five strobes -> down never asserts until left releases.
- Reset mid-ARMING after two qualifying strobes, then one more strobe -> no activation. With TILT_AUTO_REPEAT_EN and REPEAT_DELAY=4, REPEAT_PERIOD=3: pulses at activation+1, +5, +8.
